hilo_muldiv_unit: RTL and testbench

Parametrised successor to the HI/LO register pair. It adds an iterative multiply/divide engine that owns HI and LO, covering MULT, MULTU, DIV and DIVU.
- Direct HI/LO writes (MTHI/MTLO) and reads (MFHI/MFLO) are also supported.
- It sits beside the ALU in the datapath.
- The control unit stalls the pipeline while `busy` is high.

---
 rtl/hilo_muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
//   HI/LO register pair with an iterative multiply/divide engine that owns both
//   registers. Supports MULT, MULTU, DIV and DIVU (one step per clock, WIDTH
//   steps), plus direct MTHI/MTLO writes while idle. HI/LO are read directly.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   start, op           start request (sampled when idle); 00 MULT, 01 MULTU,
//                       10 DIV, 11 DIVU
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   wr_hi, wr_lo        direct write of wr_data into HI / LO (idle only)
//   busy                operation in progress
//   done, div_by_zero   one-cycle pulses when HI/LO take a result
//   hi_out, lo_out      current HI / LO contents
// -----------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;       // raw dividend, needed for divide-by-zero HI
    logic [WIDTH-1:0]   m_q, m_d;       // multiplicand / divisor magnitude
    logic [2*WIDTH-1:0] p_q, p_d;       // {acc, multiplier} or {remainder, dividend/quotient}
    logic               neg_q, neg_d;   // negate product / quotient
    logic               rneg_q, rneg_d; // negate remainder
    logic               dbz_q, dbz_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbzp_q, dbzp_d;

    logic               is_signed, sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        // operand preparation for the start cycle
        is_signed = ~op[0];
        sa        = is_signed & src_a[WIDTH-1];
        sb        = is_signed & src_b[WIDTH-1];
        a_mag     = sa ? -src_a : src_a;
        b_mag     = sb ? -src_b : src_b;

        // shift-add step: add multiplicand into the upper half, shift right
        addend    = p_q[0] ? m_q : '0;
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        mul_next  = {mul_sum, p_q[WIDTH-1:1]};

        // restoring step: the shifted partial remainder is WIDTH+1 bits wide;
        // its top bit is the old remainder MSB, so compare before truncating
        div_ge    = p_q[2*WIDTH-1] | ({p_q[2*WIDTH-2:WIDTH], p_q[WIDTH-1]} >= m_q);
        div_diff  = {p_q[2*WIDTH-2:WIDTH], p_q[WIDTH-1]} - m_q;
        div_next  = div_ge ? {div_diff, p_q[WIDTH-2:0], 1'b1}
                           : {p_q[2*WIDTH-2:0], 1'b0};

        prod_fix  = neg_q ? -p_q : p_q;
        quo       = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem       = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        m_d     = m_q;
        p_d     = p_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbzp_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start) begin
                    op_d    = op;
                    a_d     = src_a;
                    if (op[1]) begin
                        p_d = {{WIDTH{1'b0}}, a_mag};
                        m_d = b_mag;
                    end else begin
                        p_d = {{WIDTH{1'b0}}, b_mag};
                        m_d = a_mag;
                    end
                    neg_d   = sa ^ sb;
                    rneg_d  = sa & op[1];
                    dbz_d   = op[1] & (src_b == '0);
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                p_d     = op_q[1] ? div_next : mul_next;
                count_d = count_q + 1'b1;
                if (count_q == LAST) state_d = S_FIN;
            end
            S_FIN: begin
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dbz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                dbzp_d  = dbz_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbzp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            m_q     <= m_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbzp_q  <= dbzp_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbzp_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//   Directed-vector bench for hilo_muldiv_unit at WIDTH=32. Inputs are driven
//   and outputs sampled on the falling edge; the DUT acts on rising edges.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         wr_hi, wr_lo;
    logic [W-1:0] wr_data;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi_out, lo_out;

    int n_tests = 0;
    int n_fail  = 0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one operation. lat is the edge index (relative to E0) after which
    // done was first seen; busy_cnt counts samples with busy=1. When inject is
    // set, a direct HI write plus a second start are driven mid-operation.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject, output int lat, output int busy_cnt,
                         output logic dbz_at_done, output logic done_after,
                         output logic dbz_after);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);                 // E0 has occurred
        start = 1'b0; src_a = ~a; src_b = ~b;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (inject && lat == 5) begin
                wr_hi = 1'b1; wr_data = 32'hDEADBEEF; start = 1'b1; op = 2'b11;
            end else begin
                wr_hi = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        wr_hi = 1'b0; start = 1'b0;
        dbz_at_done = div_by_zero;
        check("busy_low_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        done_after = done;
        dbz_after  = div_by_zero;
    endtask

    int   lat, bc;
    logic dz, dn2, dz2;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        check("rst_hi",   {32'd0, hi_out}, 64'd0);
        check("rst_lo",   {32'd0, lo_out}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        reset_n = 1'b1;

        // MULTU max * max, with latency and busy-window checks
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, bc, dz, dn2, dz2);
        check("multu_lat",  64'(lat), 64'd33);
        check("multu_busy", 64'(bc), 64'd33);
        check("multu_hilo", {hi_out, lo_out}, 64'hFFFFFFFE_00000001);
        check("multu_done_pulse", {63'd0, dn2}, 64'd0);

        do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 0, lat, bc, dz, dn2, dz2);
        check("mult_neg", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);

        do_op(2'b00, 32'h80000000, 32'h80000000, 0, lat, bc, dz, dn2, dz2);
        check("mult_min_min", {hi_out, lo_out}, 64'h40000000_00000000);

        do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0, lat, bc, dz, dn2, dz2);
        check("div_neg", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_neg_dbz", {63'd0, dz}, 64'd0);

        do_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 0, lat, bc, dz, dn2, dz2);
        check("divu", {hi_out, lo_out}, 64'h00000001_7FFFFFFC);

        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, lat, bc, dz, dn2, dz2);
        check("div_min_m1", {hi_out, lo_out}, 64'h00000000_80000000);
        check("div_min_m1_dbz", {63'd0, dz}, 64'd0);

        do_op(2'b11, 32'h00000007, 32'h00000000, 0, lat, bc, dz, dn2, dz2);
        check("divu0_lat",  64'(lat), 64'd33);
        check("divu0_hilo", {hi_out, lo_out}, 64'h00000007_FFFFFFFF);
        check("divu0_dbz",  {63'd0, dz}, 64'd1);
        check("divu0_dbz_pulse",  {63'd0, dz2}, 64'd0);
        check("divu0_done_pulse", {63'd0, dn2}, 64'd0);

        do_op(2'b10, 32'hFFFFFFF0, 32'h00000000, 0, lat, bc, dz, dn2, dz2);
        check("div0_hilo", {hi_out, lo_out}, 64'hFFFFFFF0_FFFFFFFF);
        check("div0_dbz",  {63'd0, dz}, 64'd1);

        // idle direct writes
        @(negedge clk);
        wr_lo = 1'b1; wr_data = 32'h1234ABCD;
        @(negedge clk);
        wr_lo = 1'b0;
        check("wr_lo", {hi_out, lo_out}, 64'hFFFFFFF0_1234ABCD);
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0BADF00D;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr_both", {hi_out, lo_out}, 64'h0BADF00D_0BADF00D);

        // writes and start during RUN are ignored
        do_op(2'b01, 32'h12345678, 32'h00000010, 1, lat, bc, dz, dn2, dz2);
        check("busy_wr_ignored", {hi_out, lo_out}, 64'h00000001_23456780);
        check("busy_start_dropped", {63'd0, busy}, 64'd0);
        check("busy_start_lat", 64'(lat), 64'd33);

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_hilo", {hi_out, lo_out}, 64'd0);
        check("arst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_no_resume", {63'd0, busy}, 64'd0);

        do_op(2'b01, 32'd5, 32'd6, 0, lat, bc, dz, dn2, dz2);
        check("post_rst_hilo", {hi_out, lo_out}, 64'h00000000_0000001E);
        check("post_rst_lat", 64'(lat), 64'd33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
